// File: rtl/haz_unit_p.sv
// ---------------------------------------------------------------------------
// haz_unit_p : sequenced hazard unit for the 5-stage pipelined core.
//
// Detects load-use and branch/jump-operand hazards on the instruction in ID.
// Multi-cycle stalls are run from a registered down-counter instead of being
// re-derived every cycle. Instruction/data cache busy freezes the whole
// pipeline. A saturating performance counter tallies bubble cycles.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   id_valid                  ID holds a real instruction
//   id_rs1/id_rs1_used        ID source 1 and whether it is read
//   id_rs2/id_rs2_used        ID source 2 and whether it is read
//   id_is_bj                  ID is a branch/jump consuming rs1 in ID
//   br_taken                  branch/jump in ID resolved taken
//   ex_reg_wr/ex_rd/ex_mem_rd EX writes a register / its destination / is a load
//   imem_busy, dmem_busy      cache not ready
//   pc_we, if_id_we           PC and IF/ID write enables
//   id_ex_bubble              load a NOP into ID/EX
//   if_id_flush               clear IF/ID (taken branch)
//   pipe_freeze               hold all pipeline registers
//   stalling                  FSM is in the STALL state
//   stall_cycles              saturating count of bubble cycles
// ---------------------------------------------------------------------------
module haz_unit_p #(
  parameter int AW           = 3,
  parameter int LU_STALL     = 1,
  parameter int BJ_ALU_STALL = 1,
  parameter int BJ_LD_STALL  = 2,
  parameter int ZERO_REG     = 0,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs1,
  input  logic             id_rs1_used,
  input  logic [AW-1:0]    id_rs2,
  input  logic             id_rs2_used,
  input  logic             id_is_bj,
  input  logic             br_taken,
  input  logic             ex_reg_wr,
  input  logic [AW-1:0]    ex_rd,
  input  logic             ex_mem_rd,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             pipe_freeze,
  output logic             stalling,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  // Stall lengths fit the 3-bit down-counter.
  localparam logic [2:0] LU_N  = 3'(LU_STALL);
  localparam logic [2:0] BJA_N = 3'(BJ_ALU_STALL);
  localparam logic [2:0] BJL_N = 3'(BJ_LD_STALL);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;

  logic       rs1_match, rs2_match;
  logic       hz_en, lu, bja, bjl;
  logic [2:0] stall_len;
  logic       stall_active;

  // With a hardwired zero register, writes to r0 are discarded, so a source
  // of 0 can never depend on an in-flight result.
  always_comb begin
    rs1_match = (id_rs1 == ex_rd);
    rs2_match = (id_rs2 == ex_rd);
    if (ZERO_REG != 0) begin
      if (id_rs1 == '0) rs1_match = 1'b0;
      if (id_rs2 == '0) rs2_match = 1'b0;
    end
  end

  // Detection is masked while a stall sequence is already running.
  assign hz_en = id_valid && (state == RUN);

  assign lu  = hz_en && (LU_STALL != 0) && ex_mem_rd &&
               ((id_rs1_used && rs1_match) || (id_rs2_used && rs2_match));
  assign bja = hz_en && (BJ_ALU_STALL != 0) && id_is_bj && ex_reg_wr &&
               !ex_mem_rd && rs1_match;
  assign bjl = hz_en && (BJ_LD_STALL != 0) && id_is_bj && ex_mem_rd &&
               rs1_match;

  // Stall length is the longest requirement among the asserted terms.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    stall_len = 3'd0;
    if (lu  && (LU_N  > stall_len)) stall_len = LU_N;
    if (bja && (BJA_N > stall_len)) stall_len = BJA_N;
    if (bjl && (BJL_N > stall_len)) stall_len = BJL_N;
  end

  assign stall_active = (state == STALL) || (stall_len != 3'd0);
  assign pipe_freeze  = imem_busy || dmem_busy;
  assign stalling     = (state == STALL);

  // Output priority: freeze, then stall, then normal flow. br_taken is
  // ignored during a stall because the branch operand is not yet resolved.
  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = br_taken && id_valid;
    if (pipe_freeze) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      if_id_flush  = 1'b0;
    end else if (stall_active) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b0;
    end
  end

  // The first bubble is issued from RUN; cnt holds the bubbles still owed.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!pipe_freeze) begin
      unique case (state)
        RUN: begin
          if (stall_len > 3'd1) begin
            state_nxt = STALL;
            cnt_nxt   = stall_len - 3'd1;
          end
        end
        STALL: begin
          if (cnt <= 3'd1) begin
            state_nxt = RUN;
            cnt_nxt   = 3'd0;
          end else begin
            cnt_nxt   = cnt - 3'd1;
          end
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Bubbles are never issued while frozen, so the counter holds then too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (id_ex_bubble && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_haz_unit_p.sv
// ---------------------------------------------------------------------------
// tb_haz_unit_p : self-checking bench for haz_unit_p.
//
// Three instances with different parameter sets share one stimulus stream:
//   u0 : defaults (LU=1, BJ_ALU=1, BJ_LD=2, ZERO_REG=0, CNT_W=16)
//   u1 : LU=0, BJ_ALU=1, BJ_LD=2, ZERO_REG=1, CNT_W=2
//   u2 : LU=1, BJ_ALU=1, BJ_LD=4, ZERO_REG=0, CNT_W=16
// The reference model keeps "bubbles still owed" and a bubble tally per
// instance and derives every expected output from them.
// ---------------------------------------------------------------------------
module tb_haz_unit_p;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs1_used, id_rs2_used, id_is_bj, br_taken;
  logic [2:0] id_rs1, id_rs2, ex_rd;
  logic       ex_reg_wr, ex_mem_rd, imem_busy, dmem_busy;

  logic        pc_we [NI];
  logic        if_id_we [NI];
  logic        bub [NI];
  logic        flush [NI];
  logic        frz [NI];
  logic        stl [NI];
  logic [15:0] sc0, sc2;
  logic [1:0]  sc1;

  int checks = 0;
  int errors = 0;

  int    pend [NI];
  longint mcnt [NI];

  always #5 clk = ~clk;

  haz_unit_p u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1),
    .id_rs1_used(id_rs1_used), .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .id_is_bj(id_is_bj), .br_taken(br_taken), .ex_reg_wr(ex_reg_wr),
    .ex_rd(ex_rd), .ex_mem_rd(ex_mem_rd), .imem_busy(imem_busy),
    .dmem_busy(dmem_busy), .pc_we(pc_we[0]), .if_id_we(if_id_we[0]),
    .id_ex_bubble(bub[0]), .if_id_flush(flush[0]), .pipe_freeze(frz[0]),
    .stalling(stl[0]), .stall_cycles(sc0)
  );

  haz_unit_p #(.LU_STALL(0), .BJ_ALU_STALL(1), .BJ_LD_STALL(2),
               .ZERO_REG(1), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1),
    .id_rs1_used(id_rs1_used), .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .id_is_bj(id_is_bj), .br_taken(br_taken), .ex_reg_wr(ex_reg_wr),
    .ex_rd(ex_rd), .ex_mem_rd(ex_mem_rd), .imem_busy(imem_busy),
    .dmem_busy(dmem_busy), .pc_we(pc_we[1]), .if_id_we(if_id_we[1]),
    .id_ex_bubble(bub[1]), .if_id_flush(flush[1]), .pipe_freeze(frz[1]),
    .stalling(stl[1]), .stall_cycles(sc1)
  );

  haz_unit_p #(.LU_STALL(1), .BJ_ALU_STALL(1), .BJ_LD_STALL(4),
               .ZERO_REG(0), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1),
    .id_rs1_used(id_rs1_used), .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .id_is_bj(id_is_bj), .br_taken(br_taken), .ex_reg_wr(ex_reg_wr),
    .ex_rd(ex_rd), .ex_mem_rd(ex_mem_rd), .imem_busy(imem_busy),
    .dmem_busy(dmem_busy), .pc_we(pc_we[2]), .if_id_we(if_id_we[2]),
    .id_ex_bubble(bub[2]), .if_id_flush(flush[2]), .pipe_freeze(frz[2]),
    .stalling(stl[2]), .stall_cycles(sc2)
  );

  // ---- per-instance parameters as seen by the model ----
  function automatic int p_lu(int k);
    return (k == 1) ? 0 : 1;
  endfunction
  function automatic int p_bja(int k);
    return (k >= 0) ? 1 : 1;
  endfunction
  function automatic int p_bjl(int k);
    return (k == 2) ? 4 : 2;
  endfunction
  function automatic int p_zr(int k);
    return (k == 1) ? 1 : 0;
  endfunction
  function automatic longint p_max(int k);
    return (k == 1) ? 64'd3 : 64'd65535;
  endfunction

  function automatic longint sc_of(int k);
    case (k)
      0:       return longint'(sc0);
      1:       return longint'(sc1);
      default: return longint'(sc2);
    endcase
  endfunction

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // Bubbles a fresh hazard in ID would demand right now.
  function automatic int stall_need(int k);
    int n;
    bit m1, m2;
    n  = 0;
    m1 = (id_rs1 == ex_rd) && !(p_zr(k) != 0 && id_rs1 == 3'd0);
    m2 = (id_rs2 == ex_rd) && !(p_zr(k) != 0 && id_rs2 == 3'd0);
    if (!id_valid) return 0;
    if (ex_mem_rd && ((id_rs1_used && m1) || (id_rs2_used && m2)))
      n = imax(n, p_lu(k));
    if (id_is_bj && ex_reg_wr && !ex_mem_rd && m1) n = imax(n, p_bja(k));
    if (id_is_bj && ex_mem_rd && m1)               n = imax(n, p_bjl(k));
    return n;
  endfunction

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      pend[k] = 0;
      mcnt[k] = 0;
    end
  endtask

  // One clock cycle: compare all outputs with the model, then advance the
  // model across the rising edge. Called shortly after a rising edge.
  task automatic tick();
    bit fz, eb, ep;
    int n;
    #2;
    fz = imem_busy || dmem_busy;
    for (int k = 0; k < NI; k++) begin
      n  = stall_need(k);
      eb = !fz && (pend[k] > 0 || n > 0);
      ep = !fz && !eb;
      check($sformatf("u%0d.pc_we", k),        longint'(pc_we[k]),    longint'(ep));
      check($sformatf("u%0d.if_id_we", k),     longint'(if_id_we[k]), longint'(ep));
      check($sformatf("u%0d.bubble", k),       longint'(bub[k]),      longint'(eb));
      check($sformatf("u%0d.flush", k),        longint'(flush[k]),
            longint'(ep && br_taken && id_valid));
      check($sformatf("u%0d.freeze", k),       longint'(frz[k]),      longint'(fz));
      check($sformatf("u%0d.stalling", k),     longint'(stl[k]),      longint'(pend[k] > 0));
      check($sformatf("u%0d.stall_cycles", k), sc_of(k),              mcnt[k]);
    end
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      n  = stall_need(k);
      eb = 1'b0;
      if (!fz) begin
        if (pend[k] > 0) begin
          eb = 1'b1;
          pend[k]--;
        end else if (n > 0) begin
          eb = 1'b1;
          pend[k] = n - 1;
        end
      end
      if (eb && mcnt[k] < p_max(k)) mcnt[k]++;
    end
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
    id_is_bj = 0; br_taken = 0; ex_reg_wr = 0; ex_rd = 0; ex_mem_rd = 0;
    imem_busy = 0; dmem_busy = 0;
  endtask

  // Short asynchronous reset pulse kept clear of the clock edge.
  task automatic pulse_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    model_reset();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #3;
    check("reset.pc_we",    longint'(pc_we[0]),    1);
    check("reset.if_id_we", longint'(if_id_we[0]), 1);
    check("reset.bubble",   longint'(bub[0]),      0);
    check("reset.flush",    longint'(flush[0]),    0);
    check("reset.freeze",   longint'(frz[0]),      0);
    check("reset.stalling", longint'(stl[0]),      0);
    check("reset.count",    sc_of(0),              0);
    #4;
    rst = 1'b0;

    // Load-use on rs2: one bubble on u0/u2, ignored by u1 (LU disabled).
    id_valid = 1; ex_mem_rd = 1; ex_reg_wr = 1; ex_rd = 3;
    id_rs2 = 3; id_rs2_used = 1; id_rs1 = 1; id_rs1_used = 1;
    #1;
    check("lu.bubble",    longint'(bub[0]), 1);
    check("lu.pc_we",     longint'(pc_we[0]), 0);
    check("lu_off.bubble", longint'(bub[1]), 0);
    tick();
    idle_inputs();
    tick();
    check("lu.count", sc_of(0), 1);
    check("lu.stalling", longint'(stl[0]), 0);

    // Branch on load: two bubbles, stalling only in the second, no flush.
    pulse_reset();
    id_valid = 1; id_is_bj = 1; id_rs1 = 5; id_rs1_used = 1;
    ex_mem_rd = 1; ex_reg_wr = 1; ex_rd = 5;
    #1;
    check("bjl.bubble1",   longint'(bub[0]), 1);
    check("bjl.stalling1", longint'(stl[0]), 0);
    tick();
    br_taken = 1;
    #1;
    check("bjl.bubble2",   longint'(bub[0]),   1);
    check("bjl.stalling2", longint'(stl[0]),   1);
    check("bjl.noflush",   longint'(flush[0]), 0);
    tick();
    br_taken = 0; ex_mem_rd = 0; ex_reg_wr = 0; ex_rd = 2;
    #1;
    check("bjl.resume", longint'(pc_we[0]), 1);
    tick();
    check("bjl.count", sc_of(0), 2);

    // Branch on ALU result: one bubble, then the taken branch flushes.
    pulse_reset();
    id_valid = 1; id_is_bj = 1; id_rs1 = 4; id_rs1_used = 1;
    ex_reg_wr = 1; ex_mem_rd = 0; ex_rd = 4;
    #1;
    check("bja.bubble", longint'(bub[0]), 1);
    tick();
    ex_rd = 6; br_taken = 1;
    #1;
    check("bja.flush", longint'(flush[0]), 1);
    check("bja.pc_we", longint'(pc_we[0]), 1);
    tick();

    // Freeze mid-stall on u2 (BJ_LD_STALL=4): exactly four bubbles overall.
    pulse_reset();
    id_valid = 1; id_is_bj = 1; id_rs1 = 5; id_rs1_used = 1;
    ex_mem_rd = 1; ex_reg_wr = 1; ex_rd = 5;
    tick();
    idle_inputs();
    tick();
    dmem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("frz.freeze", longint'(frz[2]), 1);
      check("frz.bubble", longint'(bub[2]), 0);
      tick();
    end
    dmem_busy = 0;
    tick();
    tick();
    #1;
    check("frz.done", longint'(stl[2]), 0);
    tick();
    check("frz.count", sc_of(2), 4);

    // Asynchronous reset in the middle of a u2 stall.
    pulse_reset();
    id_valid = 1; id_is_bj = 1; id_rs1 = 5; id_rs1_used = 1;
    ex_mem_rd = 1; ex_reg_wr = 1; ex_rd = 5;
    tick();
    idle_inputs();
    tick();
    rst = 1'b1;
    #1;
    check("rstmid.pc_we",    longint'(pc_we[2]), 1);
    check("rstmid.bubble",   longint'(bub[2]),   0);
    check("rstmid.stalling", longint'(stl[2]),   0);
    check("rstmid.count",    sc_of(2),           0);
    model_reset();
    rst = 1'b0;
    tick();

    // Zero-register hazard: ignored by u1 (ZERO_REG=1), seen by u0.
    pulse_reset();
    id_valid = 1; id_is_bj = 1; id_rs1 = 0; id_rs1_used = 1;
    ex_mem_rd = 1; ex_reg_wr = 1; ex_rd = 0;
    #1;
    check("zr.u1_bubble", longint'(bub[1]), 0);
    check("zr.u0_bubble", longint'(bub[0]), 1);
    tick();
    idle_inputs();
    tick();
    tick();

    // Saturation: six back-to-back bubbles on a 2-bit counter.
    pulse_reset();
    id_valid = 1; id_is_bj = 1; id_rs1 = 6; id_rs1_used = 1;
    ex_mem_rd = 1; ex_reg_wr = 1; ex_rd = 6;
    for (int i = 0; i < 6; i++) tick();
    idle_inputs();
    tick();
    check("sat.u1_count", sc_of(1), 3);
    check("sat.u0_count", sc_of(0), 6);

    // Randomized traffic with hazards biased onto a small register subset.
    pulse_reset();
    for (int i = 0; i < 3000; i++) begin
      id_valid    = ($urandom_range(0, 9) != 0);
      id_rs1      = 3'($urandom_range(0, 3));
      id_rs2      = 3'($urandom_range(0, 3));
      ex_rd       = 3'($urandom_range(0, 3));
      id_rs1_used = 1'($urandom_range(0, 1));
      id_rs2_used = 1'($urandom_range(0, 1));
      id_is_bj    = ($urandom_range(0, 2) == 0);
      br_taken    = 1'($urandom_range(0, 1));
      ex_reg_wr   = ($urandom_range(0, 3) != 0);
      ex_mem_rd   = ex_reg_wr && ($urandom_range(0, 1) != 0);
      imem_busy   = ($urandom_range(0, 11) == 0);
      dmem_busy   = ($urandom_range(0, 11) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/haz_unit_p.md
Name: haz_unit_p

Overview:
- Parametrised, sequenced hazard unit for the 5-stage pipelined core; successor to the single-cycle combinational hazard detector.
- Detects load-use and branch/jump-operand hazards on the instruction in ID and generates multi-cycle stalls from a registered down-counter instead of re-deriving them each cycle.
- Freezes the whole pipeline on instruction/data cache busy.
- Gates the taken-branch flush and keeps a saturating stall-cycle performance counter.

Parameters:
- AW, 3, register-address width.
- LU_STALL, 1, bubbles for a load in EX feeding either ID source (0 disables the check).
- BJ_ALU_STALL, 1, bubbles for a branch/jump whose rs1 is written by a non-load in EX (0 disables).
- BJ_LD_STALL, 2, bubbles for a branch/jump whose rs1 is written by a load in EX (0 disables).
- ZERO_REG, 0, 1 = register 0 is hardwired and never creates a hazard.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  AW  ID source 1
- id_rs1_used  in  1  ID reads rs1
- id_rs2  in  AW  ID source 2
- id_rs2_used  in  1  ID reads rs2
- id_is_bj  in  1  ID is a branch/jump that consumes rs1 in ID
- br_taken  in  1  branch/jump in ID resolved taken
- ex_reg_wr  in  1  EX instruction writes a register
- ex_rd  in  AW  EX destination
- ex_mem_rd  in  1  EX instruction is a load
- imem_busy  in  1  instruction cache not ready
- dmem_busy  in  1  data cache not ready
- pc_we  out  1  PC write enable
- if_id_we  out  1  IF/ID write enable
- id_ex_bubble  out  1  load NOP into ID/EX
- if_id_flush  out  1  clear IF/ID
- pipe_freeze  out  1  hold all pipeline registers
- stalling  out  1  state is STALL
- stall_cycles  out  CNT_W  saturating count of bubble cycles

Behaviour:
- Match rules: a field "matches" when equal to ex_rd. With ZERO_REG=1, a field equal to 0 never matches.
- Hazard terms, evaluated only when id_valid=1 and state is RUN:
  - lu = ex_mem_rd & ((id_rs1_used & rs1 match) | (id_rs2_used & rs2 match))
  - bja = id_is_bj & ex_reg_wr & ~ex_mem_rd & rs1 match
  - bjl = id_is_bj & ex_mem_rd & rs1 match
  - A term whose parameter is 0 is forced to 0.
- Stall length N = max of the parameter values of the asserted terms. Example: bjl and lu together give max(BJ_LD_STALL, LU_STALL).
- FSM states: RUN and STALL. Counter cnt is 3 bits.
  - RUN, N>0, no freeze: this cycle is bubble 1. If N>1, go to STALL with cnt=N-1; otherwise stay in RUN.
  - STALL, no freeze: bubble asserted every cycle; cnt decrements. Return to RUN in the cycle after cnt reaches 1, i.e. exactly N bubble cycles in total.
  - Hazard detection is masked in STALL. It is re-evaluated combinationally on the first RUN cycle.
- Stall outputs, while a stall is active (hazard detected in RUN, or state STALL):
  - pc_we=0, if_id_we=0, id_ex_bubble=1.
  - if_id_flush=0, because br_taken is ignored while the operand is unresolved.
- Freeze: pipe_freeze = imem_busy | dmem_busy, purely combinational.
  - While frozen: pc_we=0, if_id_we=0, id_ex_bubble=0, if_id_flush=0.
  - State, cnt and stall_cycles hold.
  - Freeze has priority over stall and flush.
  - A hazard visible during freeze is not latched. It is detected on the first unfrozen RUN cycle.
- Normal operation (no stall, no freeze): pc_we=1, if_id_we=1, id_ex_bubble=0, if_id_flush = br_taken & id_valid.
- stall_cycles increments on every cycle with id_ex_bubble=1 and saturates at all-ones.
- stalling = (state==STALL).
- Reset, asynchronous and effective immediately, including mid-stall:
  - State RUN, cnt=0, stall_cycles=0.
  - With busy inputs low, outputs are pc_we=1, if_id_we=1, id_ex_bubble=0, if_id_flush=0, pipe_freeze=0, stalling=0.
- All outputs are combinational from state, cnt and the inputs. There is no added latency.

Test Plan:
- Load-use: ex_mem_rd=1, ex_rd=3, id_rs2=3, id_rs2_used=1 -> exactly 1 cycle with pc_we=0 and id_ex_bubble=1, then RUN; stall_cycles=1.
- Branch on load: id_is_bj=1, id_rs1=5, ex_mem_rd=1, ex_rd=5 -> 2 consecutive bubble cycles; stalling=1 in the second cycle only. A br_taken=1 pulse during the stall gives if_id_flush=0.
- Branch on ALU result: id_is_bj=1, ex_reg_wr=1, ex_mem_rd=0, rs1 matches -> 1 bubble. Then br_taken=1 -> if_id_flush=1 in the following RUN cycle.
- Freeze mid-stall: BJ_LD_STALL=4; assert dmem_busy for 3 cycles after the 2nd bubble -> those cycles show pipe_freeze=1 with bubble=0. Exactly 4 bubbles in total; stall_cycles=4.
- Reset mid-stall: rst asserted asynchronously in STALL -> outputs return to the run values immediately and stall_cycles=0.
- Parameter and boundary checks:
  - ZERO_REG=1, ex_rd=0, rs1=0, load in EX -> no stall.
  - LU_STALL=0 -> load-use ignored.
  - CNT_W=2 after 5 bubbles -> stall_cycles=3.
